// File: rtl/bet_pkg.sv
// Shared constants, FSM state encoding and bet-word layout for the roulette
// bet round sequencer.
package bet_pkg;

  localparam int unsigned BET_W   = 8;
  localparam int unsigned OP_W    = 6;
  localparam int unsigned AMT_W   = 2;
  localparam int unsigned OP_LSB  = 0;
  localparam int unsigned AMT_LSB = 6;

  localparam logic [OP_W-1:0] SPIN_OPCODE = 6'b111110;
  localparam logic [OP_W-1:0] NULL_OPCODE = 6'b111111;

  typedef enum logic [1:0] {
    S_OPEN     = 2'd0,
    S_SPIN_REQ = 2'd1,
    S_SPINNING = 2'd2,
    S_CLOSED   = 2'd3
  } state_e;

  function automatic logic [BET_W-1:0] pack_bet(input logic [AMT_W-1:0] amt,
                                                input logic [OP_W-1:0]  op);
    logic [BET_W-1:0] w;
    w = '0;
    w[AMT_LSB +: AMT_W] = amt;
    w[OP_LSB  +: OP_W]  = op;
    return w;
  endfunction

endpackage

// File: rtl/spin_watchdog.sv
// Clearable, enabled down-counter; tc_o flags the last enabled cycle of a
// SPIN_TIMEOUT-cycle window.
module spin_watchdog #(
  parameter int unsigned SPIN_TIMEOUT = 100_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CW = (SPIN_TIMEOUT > 1) ? $clog2(SPIN_TIMEOUT) : 1;
  localparam logic [CW-1:0] LOAD = CW'(SPIN_TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = LOAD;
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= LOAD;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = en_i && !clr_i && (cnt_q == '0);

endmodule

// File: rtl/bet_round_sequencer.sv
// Roulette round controller: accepts chip-backed bets into slots, locks the
// table for a spin, waits for the result under a watchdog, then stays closed.
module bet_round_sequencer
  import bet_pkg::*;
#(
  parameter int unsigned MAX_BETS     = 12,
  parameter int unsigned SPIN_TIMEOUT = 100_000_000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [5:0]       bet_opcode,
  input  logic             chip_present,
  input  logic [1:0]       chip_amount,
  input  logic             spin_done,
  input  logic             clear_bets,
  output logic             slot_we,
  output logic [3:0]       slot_idx,
  output logic [BET_W-1:0] slot_data,
  output logic [3:0]       bet_count,
  output logic             spin_start,
  output logic             spinning,
  output logic             table_open,
  output logic             err_pulse
);

  state_e           state_q, state_d;
  logic [3:0]       count_q, count_d;
  logic [1:0]       amt_q, amt_d;
  logic [3:0]       idx_q, idx_d;
  logic [BET_W-1:0] data_q, data_d;
  logic             we_q, we_d, err_q, err_d;
  logic             start_q, spinning_q, open_q;
  logic             wd_tc, is_bet, is_spin;

  spin_watchdog #(.SPIN_TIMEOUT(SPIN_TIMEOUT)) u_wdog (
    .clock (clock),
    .reset (reset),
    .clr_i (state_q != S_SPINNING),
    .en_i  (state_q == S_SPINNING),
    .tc_o  (wd_tc)
  );

  assign is_bet  = key_valid && (bet_opcode != SPIN_OPCODE) && (bet_opcode != NULL_OPCODE);
  assign is_spin = key_valid && (bet_opcode == SPIN_OPCODE);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    amt_d   = amt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      S_OPEN: begin
        if (chip_present) amt_d = chip_amount;
        // Accepts need chip_present, so the slot word carries this cycle's amount.
        if (clear_bets) begin
          count_d = '0;
          idx_d   = '0;
        end else if (is_bet) begin
          if (chip_present && (count_q < 4'(MAX_BETS))) begin
            we_d    = 1'b1;
            idx_d   = count_q;
            data_d  = pack_bet(amt_d, bet_opcode);
            count_d = count_q + 4'd1;
          end else begin
            err_d = 1'b1;
          end
        end else if (is_spin) begin
          if (count_q != '0) state_d = S_SPIN_REQ;
          else               err_d   = 1'b1;
        end
      end
      S_SPIN_REQ: state_d = S_SPINNING;
      S_SPINNING: begin
        if (spin_done) begin
          state_d = S_CLOSED;
        end else if (wd_tc) begin
          err_d   = 1'b1;
          state_d = S_CLOSED;
        end
      end
      S_CLOSED: begin
        if (clear_bets) begin
          count_d = '0;
          idx_d   = '0;
          state_d = S_OPEN;
        end
      end
      default: state_d = S_OPEN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_OPEN;
      count_q    <= '0;
      amt_q      <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
      spinning_q <= 1'b0;
      open_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      amt_q      <= amt_d;
      idx_q      <= idx_d;
      data_q     <= data_d;
      we_q       <= we_d;
      err_q      <= err_d;
      start_q    <= (state_d == S_SPIN_REQ);
      spinning_q <= (state_d == S_SPINNING);
      open_q     <= (state_d == S_OPEN);
    end
  end

  assign slot_we    = we_q;
  assign slot_idx   = idx_q;
  assign slot_data  = data_q;
  assign bet_count  = count_q;
  assign spin_start = start_q;
  assign spinning   = spinning_q;
  assign table_open = open_q;
  assign err_pulse  = err_q;

endmodule

// File: tb/tb_bet_round_sequencer.sv
// Directed bench for bet_round_sequencer with a short spin watchdog.
module tb_bet_round_sequencer;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_valid, chip_present, spin_done, clear_bets;
  logic [5:0] bet_opcode;
  logic [1:0] chip_amount;
  logic       slot_we, spin_start, spinning, table_open, err_pulse;
  logic [3:0] slot_idx, bet_count;
  logic [7:0] slot_data;

  int vectors = 0;
  int miscompares = 0;

  bet_round_sequencer #(.MAX_BETS(12), .SPIN_TIMEOUT(16)) dut (
    .clock        (clock),
    .reset        (reset),
    .key_valid    (key_valid),
    .bet_opcode   (bet_opcode),
    .chip_present (chip_present),
    .chip_amount  (chip_amount),
    .spin_done    (spin_done),
    .clear_bets   (clear_bets),
    .slot_we      (slot_we),
    .slot_idx     (slot_idx),
    .slot_data    (slot_data),
    .bet_count    (bet_count),
    .spin_start   (spin_start),
    .spinning     (spinning),
    .table_open   (table_open),
    .err_pulse    (err_pulse)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b1; key_valid = 1'b0; bet_opcode = '0; chip_present = 1'b0;
    chip_amount = '0; spin_done = 1'b0; clear_bets = 1'b0;
    #12;
    chk("rst_open", 8'(table_open), 8'd1);
    chk("rst_count", 8'(bet_count), 8'd0);
    chk("rst_we", 8'(slot_we), 8'd0);
    chk("rst_idx", 8'(slot_idx), 8'd0);
    chk("rst_data", slot_data, 8'h00);
    chk("rst_spinning", 8'(spinning), 8'd0);
    chk("rst_err", 8'(err_pulse), 8'd0);
    chk("rst_start", 8'(spin_start), 8'd0);
    reset = 1'b0;
    tick();

    // First bet: amount 2'b10, opcode 5
    chip_present = 1'b1; chip_amount = 2'b10; bet_opcode = 6'd5; key_valid = 1'b1;
    tick();
    chk("b0_we", 8'(slot_we), 8'd1);
    chk("b0_idx", 8'(slot_idx), 8'd0);
    chk("b0_data", slot_data, 8'h85);
    chk("b0_count", 8'(bet_count), 8'd1);
    chk("b0_err", 8'(err_pulse), 8'd0);

    for (int i = 1; i < 12; i++) begin
      bet_opcode = 6'(i);
      tick();
      chk("bn_we", 8'(slot_we), 8'd1);
      chk("bn_idx", 8'(slot_idx), 8'(i));
      chk("bn_data", slot_data, 8'h80 | 8'(i));
      chk("bn_count", 8'(bet_count), 8'(i + 1));
    end

    bet_opcode = 6'd7;
    tick();
    key_valid = 1'b0;
    chk("full_we", 8'(slot_we), 8'd0);
    chk("full_err", 8'(err_pulse), 8'd1);
    chk("full_count", 8'(bet_count), 8'd12);
    chk("full_idx", 8'(slot_idx), 8'd11);
    tick();
    chk("full_err_1cyc", 8'(err_pulse), 8'd0);

    clear_bets = 1'b1;
    tick();
    clear_bets = 1'b0;
    chk("clr_count", 8'(bet_count), 8'd0);
    chk("clr_idx", 8'(slot_idx), 8'd0);
    chk("clr_open", 8'(table_open), 8'd1);

    // Spin with empty table
    bet_opcode = 6'b111110; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk("spin0_err", 8'(err_pulse), 8'd1);
    chk("spin0_start", 8'(spin_start), 8'd0);
    chk("spin0_open", 8'(table_open), 8'd1);
    tick();
    chk("spin0_start2", 8'(spin_start), 8'd0);
    chk("spin0_err2", 8'(err_pulse), 8'd0);

    bet_opcode = 6'b111111; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk("null_we", 8'(slot_we), 8'd0);
    chk("null_err", 8'(err_pulse), 8'd0);
    chk("null_count", 8'(bet_count), 8'd0);

    chip_present = 1'b0; bet_opcode = 6'd9; key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk("nochip_err", 8'(err_pulse), 8'd1);
    chk("nochip_we", 8'(slot_we), 8'd0);
    chk("nochip_count", 8'(bet_count), 8'd0);

    // Three bets at amount 2'b01, then spin
    chip_present = 1'b1; chip_amount = 2'b01; key_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bet_opcode = 6'(i);
      tick();
      chk("r3_idx", 8'(slot_idx), 8'(i - 1));
      chk("r3_data", slot_data, 8'h40 | 8'(i));
    end
    bet_opcode = 6'b111110;
    tick();
    key_valid = 1'b0;
    chk("req_start", 8'(spin_start), 8'd1);
    chk("req_open", 8'(table_open), 8'd0);
    chk("req_spinning", 8'(spinning), 8'd0);
    chk("req_count", 8'(bet_count), 8'd3);
    bet_opcode = 6'd4; key_valid = 1'b1; clear_bets = 1'b1;
    tick();
    clear_bets = 1'b0;
    chk("sp_start_off", 8'(spin_start), 8'd0);
    chk("sp_spinning", 8'(spinning), 8'd1);
    chk("sp_we", 8'(slot_we), 8'd0);
    chk("sp_count", 8'(bet_count), 8'd3);
    tick();
    key_valid = 1'b0;
    chk("sp_key_we", 8'(slot_we), 8'd0);
    chk("sp_key_err", 8'(err_pulse), 8'd0);
    chk("sp_key_spin", 8'(spinning), 8'd1);
    spin_done = 1'b1;
    tick();
    spin_done = 1'b0;
    chk("done_spinning", 8'(spinning), 8'd0);
    chk("done_open", 8'(table_open), 8'd0);
    chk("done_err", 8'(err_pulse), 8'd0);
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
    chk("closed_we", 8'(slot_we), 8'd0);
    chk("closed_count", 8'(bet_count), 8'd3);
    clear_bets = 1'b1;
    tick();
    clear_bets = 1'b0;
    chk("reopen_count", 8'(bet_count), 8'd0);
    chk("reopen_open", 8'(table_open), 8'd1);
    chk("reopen_idx", 8'(slot_idx), 8'd0);
    spin_done = 1'b1;
    tick();
    spin_done = 1'b0;
    chk("stray_done_spin", 8'(spinning), 8'd0);
    chk("stray_done_open", 8'(table_open), 8'd1);

    // Watchdog timeout: err 16 cycles after entering SPINNING
    bet_opcode = 6'd10; key_valid = 1'b1;
    tick();
    bet_opcode = 6'b111110;
    tick();
    key_valid = 1'b0;
    tick();
    chk("to_spinning", 8'(spinning), 8'd1);
    for (int i = 1; i < 16; i++) begin
      tick();
      chk("to_wait_err", 8'(err_pulse), 8'd0);
    end
    tick();
    chk("to_err", 8'(err_pulse), 8'd1);
    chk("to_spinning_off", 8'(spinning), 8'd0);
    tick();
    chk("to_err_1cyc", 8'(err_pulse), 8'd0);
    chk("to_closed", 8'(table_open), 8'd0);
    clear_bets = 1'b1;
    tick();
    clear_bets = 1'b0;

    // spin_done landing on the timeout cycle counts as done
    bet_opcode = 6'd11; key_valid = 1'b1;
    tick();
    bet_opcode = 6'b111110;
    tick();
    key_valid = 1'b0;
    tick();
    for (int i = 1; i < 16; i++) tick();
    spin_done = 1'b1;
    tick();
    spin_done = 1'b0;
    chk("tie_err", 8'(err_pulse), 8'd0);
    chk("tie_spinning", 8'(spinning), 8'd0);
    tick();
    chk("tie_closed", 8'(table_open), 8'd0);
    clear_bets = 1'b1;
    tick();
    clear_bets = 1'b0;

    // Asynchronous reset between edges while spinning
    bet_opcode = 6'd12; key_valid = 1'b1;
    tick();
    bet_opcode = 6'b111110;
    tick();
    key_valid = 1'b0;
    tick();
    chk("ar_pre_spin", 8'(spinning), 8'd1);
    #2 reset = 1'b1;
    #1;
    chk("ar_spinning", 8'(spinning), 8'd0);
    chk("ar_open", 8'(table_open), 8'd1);
    chk("ar_count", 8'(bet_count), 8'd0);
    chk("ar_data", slot_data, 8'h00);
    #1 reset = 1'b0;

    bet_opcode = 6'd13; key_valid = 1'b1; clear_bets = 1'b1;
    tick();
    key_valid = 1'b0; clear_bets = 1'b0;
    chk("clrbet_we", 8'(slot_we), 8'd0);
    chk("clrbet_count", 8'(bet_count), 8'd0);
    chk("clrbet_err", 8'(err_pulse), 8'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bet_round_sequencer.md
Name: bet_round_sequencer

Overview:
Round controller for the roulette table. It accepts bets from keyboard opcodes and the Arduino chip sensor, and assigns each accepted bet to one of MAX_BETS slots. It locks the table on the spin key and requests a wheel spin. It then waits for the processor's result-ready pulse, with a watchdog, and holds the table closed until the next round is cleared. It drives the bet-slot register bank and the bet-count display.

Parameters:
MAX_BETS, 12, number of bet slots (max 15)
BET_W, 8, slot width: {amount[1:0], opcode[5:0]}
SPIN_OPCODE, 6'b111110, opcode that requests a spin
NULL_OPCODE, 6'b111111, opcode meaning "no valid key"
SPIN_TIMEOUT, 100_000_000, max cycles to wait for spin_done

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high; clears all state
key_valid  in  1  one-cycle pulse: new decoded key present on bet_opcode
bet_opcode  in  6  decoded bet opcode
chip_present  in  1  Arduino chip-detect (JB[2])
chip_amount  in  2  Arduino chip colour/amount (JB[1:0])
spin_done  in  1  one-cycle pulse: spin result and payout finished
clear_bets  in  1  one-cycle pulse: start a new round
slot_we  out  1  write strobe to the bet-slot bank
slot_idx  out  4  slot index, 0..MAX_BETS-1
slot_data  out  BET_W  bet word to write
bet_count  out  4  number of accepted bets this round
spin_start  out  1  one-cycle spin request to the wheel/processor
spinning  out  1  high while waiting for spin_done
table_open  out  1  high in OPEN state
err_pulse  out  1  one-cycle pulse on a rejected action or timeout

Behaviour:
- Reset (async): state=OPEN; bet_count=0; amt_latch=0; all strobes=0; spinning=0; table_open=1; slot_idx=0; slot_data=0.
- amt_latch: loads chip_amount on every cycle chip_present=1, and holds otherwise. It does not change outside OPEN.
- All outputs are registered. Each strobe is exactly one cycle wide, asserted the cycle after its triggering input.
- States: OPEN, SPIN_REQ, SPINNING, CLOSED.
- OPEN, bet accept: key_valid=1, opcode not SPIN_OPCODE or NULL_OPCODE, chip_present=1, bet_count<MAX_BETS.
  - Next cycle: slot_we=1, slot_idx=bet_count (old value), slot_data={amt_latch, bet_opcode}.
  - bet_count increments in the same cycle as slot_we.
- OPEN, bet reject: same key but chip_present=0 or bet_count==MAX_BETS. Result: err_pulse, no write, count unchanged.
- OPEN, NULL_OPCODE: ignored silently.
- OPEN, spin key: key_valid with SPIN_OPCODE.
  - bet_count>0: go to SPIN_REQ.
  - bet_count==0: err_pulse, stay in OPEN.
- SPIN_REQ: spin_start=1 for one cycle, then go to SPINNING. table_open=0 from this cycle on.
- SPINNING:
  - spinning=1, all keys ignored, watchdog counts cycles.
  - spin_done: go to CLOSED.
  - Watchdog reaches SPIN_TIMEOUT-1 without spin_done: err_pulse, go to CLOSED.
- CLOSED: keys ignored. clear_bets → bet_count=0, slot_idx=0, go to OPEN.
- clear_bets while in OPEN: also zeroes bet_count. If it coincides with a bet accept, clear wins and the bet is dropped (no slot_we).
- clear_bets in SPIN_REQ/SPINNING: ignored (no abort mid-spin).
- spin_done outside SPINNING: ignored.
- spin_done on the same cycle as timeout: treated as done, no err_pulse.
- bet_count saturates at MAX_BETS and never wraps.
- Reset mid-spin: immediate return to OPEN with an empty table. The slot bank is cleared by its own reset.

Decomposition:
- Package bet_pkg holds:
  - constants SPIN_OPCODE, NULL_OPCODE, BET_W;
  - state encoding (OPEN=2'd0, SPIN_REQ=2'd1, SPINNING=2'd2, CLOSED=2'd3);
  - slot-word field positions.
- Sub-module spin_watchdog: a clearable, enabled down-counter with a terminal-count pulse, parameterised by SPIN_TIMEOUT. Instantiated once.

Test Plan:
- Reset, then chip_present=1, chip_amount=2'b10, key_valid with opcode 6'd5 → next cycle slot_we=1, slot_idx=0, slot_data=8'h85; bet_count=1.
- 12 accepted bets, then a 13th with opcode 6'd7 → the 13th gives err_pulse and no slot_we; bet_count stays 12; slot_idx sequence 0..11.
- Spin key with bet_count=0 → err_pulse, state stays OPEN, spin_start never asserts.
- 3 bets, then spin key → spin_start one cycle, table_open=0, spinning=1. Further bet keys cause no writes. spin_done → spinning=0. clear_bets → bet_count=0, table_open=1.
- SPIN_TIMEOUT=16: spin without spin_done → err_pulse 16 cycles after entering SPINNING, then state CLOSED.
- Async reset asserted mid-SPINNING (between clock edges) → outputs return to reset values immediately; clear_bets on the same cycle as a valid bet → no slot_we, bet_count=0.
